spi_xfer_ctrl: RTL and testbench

Byte-transfer controller sitting directly upstream of the SD-card MOSI left-shift stage.
- Accepts a parallel byte and a start strobe on the system clock.
- Loads the shift stage and strobes its shift clock and enable.
- Generates the SPI bus clock and chip select, and samples MISO into a receive register.
- Provides a start/busy/done handshake to the SD command sequencer.

---
 rtl/spi_pkg.sv | 6 +
 rtl/spi_half_timer.sv | 26 ++
 rtl/spi_xfer_ctrl.sv | 125 ++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and default sizes for the SPI byte-transfer controller.
package spi_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, LEAD, HIGH, LOW, DONE} spi_state_t;
  localparam int SPI_N_DEF   = 8;
  localparam int SPI_DIV_DEF = 4;
endpackage

// File: rtl/spi_half_timer.sv
// SPI half-period timer: counts 0..DIV-1, tick flags the last cycle, restart forces 0.
module spi_half_timer import spi_pkg::*; #(
  parameter int DIV = SPI_DIV_DEF,
  parameter int CW  = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI byte-transfer controller driving the MOSI shift stage, SCLK/CS_N and MISO capture.
// Define SPI_CS_HOLD_EN to add the cs_hold input that keeps cs_n low across transfers.
module spi_xfer_ctrl import spi_pkg::*; #(
  parameter int N   = SPI_N_DEF,
  parameter int DIV = SPI_DIV_DEF,
  parameter int CW  = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] tx_data,
  input  logic         miso,
`ifdef SPI_CS_HOLD_EN
  input  logic         cs_hold,
`endif
  output logic         sclk,
  output logic         cs_n,
  output logic [N-1:0] shift_data,
  output logic         shift_load,
  output logic         shift_clk,
  output logic         shift_en,
  output logic [N-1:0] rx_data,
  output logic         busy,
  output logic         done
);
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  spi_state_t    state_q;
  logic [CW-1:0] bitcnt_q;
  logic [N-1:0]  rx_shift_q, rx_q, shift_data_q;
  logic          sclk_q, cs_n_q, shift_load_q, shift_clk_q, shift_en_q, busy_q, done_q;
  logic          hold_q;
  logic          tick, restart;

  // Only the timed phases let the half-period counter run.
  assign restart = !(state_q inside {LEAD, HIGH, LOW});

  spi_half_timer #(.DIV(DIV), .CW(CW)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      bitcnt_q     <= '0;
      rx_shift_q   <= '0;
      rx_q         <= '0;
      shift_data_q <= '0;
      sclk_q       <= 1'b0;
      cs_n_q       <= 1'b1;
      shift_load_q <= 1'b0;
      shift_clk_q  <= 1'b0;
      shift_en_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      hold_q       <= 1'b0;
    end else begin
      shift_load_q <= 1'b0;
      shift_clk_q  <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          shift_data_q <= tx_data;
`ifdef SPI_CS_HOLD_EN
          hold_q       <= cs_hold;
`else
          hold_q       <= 1'b0;
`endif
          shift_load_q <= 1'b1;
          cs_n_q       <= 1'b0;
          busy_q       <= 1'b1;
          shift_en_q   <= 1'b1;
          state_q      <= LOAD;
        end
        LOAD: begin
          // First shift pulse presents the MSB before the first SCLK rise.
          shift_clk_q <= 1'b1;
          state_q     <= LEAD;
        end
        LEAD: if (tick) begin
          bitcnt_q <= '0;
          sclk_q   <= 1'b1;
          state_q  <= HIGH;
        end
        HIGH: if (tick) begin
          rx_shift_q  <= {rx_shift_q[N-2:0], miso};
          sclk_q      <= 1'b0;
          shift_clk_q <= (bitcnt_q != LAST_BIT);
          state_q     <= LOW;
        end
        LOW: if (tick) begin
          if (bitcnt_q == LAST_BIT) begin
            done_q  <= 1'b1;
            rx_q    <= rx_shift_q;
            state_q <= DONE;
          end else begin
            bitcnt_q <= bitcnt_q + CW'(1);
            sclk_q   <= 1'b1;
            state_q  <= HIGH;
          end
        end
        DONE: begin
          cs_n_q     <= !hold_q;
          shift_en_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sclk       = sclk_q;
  assign cs_n       = cs_n_q;
  assign shift_data = shift_data_q;
  assign shift_load = shift_load_q;
  assign shift_clk  = shift_clk_q;
  assign shift_en   = shift_en_q;
  assign rx_data    = rx_q;
  assign busy       = busy_q;
  assign done       = done_q;
endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Self-checking bench for spi_xfer_ctrl: an 8-bit/DIV=2 instance and a 16-bit/DIV=5 instance.
module tb_spi_xfer_ctrl;
  localparam int N8 = 8, D8 = 2, N16 = 16, D16 = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start8, miso8;
  logic [7:0]  tx8;
  logic        sclk8, cs_n8, sl8, sc8, se8, busy8, done8;
  logic [7:0]  sd8, rx8;
  logic        start16, miso16;
  logic [15:0] tx16;
  logic        sclk16, cs_n16, sl16, sc16, se16, busy16, done16;
  logic [15:0] sd16, rx16;
`ifdef SPI_CS_HOLD_EN
  logic hold8  = 1'b0;
  logic hold16 = 1'b0;
`endif

  spi_xfer_ctrl #(.N(N8), .DIV(D8), .CW(4)) dut (
    .clk(clk), .reset(reset), .start(start8), .tx_data(tx8), .miso(miso8),
`ifdef SPI_CS_HOLD_EN
    .cs_hold(hold8),
`endif
    .sclk(sclk8), .cs_n(cs_n8), .shift_data(sd8), .shift_load(sl8), .shift_clk(sc8),
    .shift_en(se8), .rx_data(rx8), .busy(busy8), .done(done8)
  );

  spi_xfer_ctrl #(.N(N16), .DIV(D16), .CW(5)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .tx_data(tx16), .miso(miso16),
`ifdef SPI_CS_HOLD_EN
    .cs_hold(hold16),
`endif
    .sclk(sclk16), .cs_n(cs_n16), .shift_data(sd16), .shift_load(sl16), .shift_clk(sc16),
    .shift_en(se16), .rx_data(rx16), .busy(busy16), .done(done16)
  );

  int total = 0, bad = 0;

  // Reference model of the downstream shift stage and bus observers.
  logic [7:0] stage8, mosi_got, miso_word;
  logic       mosi8, prev_sclk;
  int         n_rise, n_shclk, n_done, n_load, n_en, n_busy, fall_cnt, cs_hi;
  logic       idle_cs, idle_busy;

  task automatic clear8();
    n_rise = 0; n_shclk = 0; n_done = 0; n_load = 0; n_en = 0; n_busy = 0;
    fall_cnt = 0; cs_hi = 0; mosi_got = '0;
  endtask

  task automatic tick8();
    @(negedge clk);
    if (sl8) begin stage8 = sd8; n_load++; end
    if (sc8) begin mosi8 = stage8[7]; stage8 = {stage8[6:0], 1'b0}; n_shclk++; end
    if (sclk8 && !prev_sclk) begin mosi_got = {mosi_got[6:0], mosi8}; n_rise++; end
    if (!sclk8 && prev_sclk) begin
      fall_cnt++;
      if (fall_cnt < 8) miso8 = miso_word[7 - fall_cnt];
    end
    prev_sclk = sclk8;
    if (done8) n_done++;
    if (se8) n_en++;
    if (busy8) n_busy++;
    if (cs_n8) cs_hi++;
  endtask

  // One IDLE cycle, then start for start_cycles cycles; returns at the done cycle.
  task automatic xfer8(input logic [7:0] tx, input logic [7:0] mw, input int start_cycles,
                       output int lat);
    tick8();
    idle_cs = cs_n8; idle_busy = busy8;
    clear8();
    miso_word = mw; miso8 = mw[7]; tx8 = tx; start8 = 1'b1;
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      tick8();
      if (k >= start_cycles) start8 = 1'b0;
      if (done8 && lat < 0) lat = k;
      if (lat >= 0 && k >= start_cycles) break;
    end
    start8 = 1'b0;
    total++;
    if (lat < 0) begin bad++; $display("FAIL xfer8_timeout got=no_done want=done tx=%h", tx); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({cs_n8, sclk8, sl8, sc8, se8, busy8, done8} !== 7'b1000000) begin
      bad++; $display("FAIL reset_ctrl got=%b want=1000000", {cs_n8, sclk8, sl8, sc8, se8, busy8, done8});
    end
    total++;
    if (rx8 !== 8'h00 || sd8 !== 8'h00) begin
      bad++; $display("FAIL reset_data got=%h/%h want=00/00", rx8, sd8);
    end
    total++;
    if ({cs_n16, sclk16, sl16, sc16, se16, busy16, done16} !== 7'b1000000 || rx16 !== 16'h0) begin
      bad++; $display("FAIL reset_wide got=%b/%h want=1000000/0000", {cs_n16, sclk16, sl16, sc16, se16, busy16, done16}, rx16);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    int exp_lat = 2 + D8 + 2 * N8 * D8;
    xfer8(8'hA5, 8'h3C, 1, lat);
    total++; if (lat !== exp_lat) begin bad++; $display("FAIL basic_latency got=%0d want=%0d", lat, exp_lat); end
    total++; if (mosi_got !== 8'hA5) begin bad++; $display("FAIL basic_mosi got=%h want=a5", mosi_got); end
    total++; if (rx8 !== 8'h3C) begin bad++; $display("FAIL basic_rx got=%h want=3c", rx8); end
    total++; if (n_rise !== N8 || n_shclk !== N8) begin
      bad++; $display("FAIL basic_pulses got=%0d/%0d want=%0d/%0d", n_rise, n_shclk, N8, N8);
    end
    total++; if (n_load !== 1 || n_done !== 1 || sd8 !== 8'hA5) begin
      bad++; $display("FAIL basic_strobes got=%0d/%0d/%h want=1/1/a5", n_load, n_done, sd8);
    end
    total++; if (n_en !== exp_lat || n_busy !== exp_lat || cs_hi !== 0) begin
      bad++; $display("FAIL basic_windows got=%0d/%0d/%0d want=%0d/%0d/0", n_en, n_busy, cs_hi, exp_lat, exp_lat);
    end
    tick8();
    total++; if ({cs_n8, busy8, se8, done8} !== 4'b1000) begin
      bad++; $display("FAIL basic_after got=%b want=1000", {cs_n8, busy8, se8, done8});
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2;
    int exp_lat = 2 + D8 + 2 * N8 * D8;
    xfer8(8'hFF, 8'hFF, 1, lat1);
    total++; if (rx8 !== 8'hFF || cs_hi !== 0) begin
      bad++; $display("FAIL b2b_first got=%h/%0d want=ff/0", rx8, cs_hi);
    end
    xfer8(8'h00, 8'hFF, 1, lat2);
    total++; if (idle_cs !== 1'b1 || idle_busy !== 1'b0) begin
      bad++; $display("FAIL b2b_gap got=%b/%b want=1/0", idle_cs, idle_busy);
    end
    total++; if (lat2 !== exp_lat || cs_hi !== 0) begin
      bad++; $display("FAIL b2b_second got=%0d/%0d want=%0d/0", lat2, cs_hi, exp_lat);
    end
    total++; if (rx8 !== 8'hFF || mosi_got !== 8'h00) begin
      bad++; $display("FAIL b2b_data got=%h/%h want=ff/00", rx8, mosi_got);
    end
  endtask

  task automatic test_start_held();
    int lat;
    logic [7:0] tx = 8'($urandom);
    logic [7:0] mw = 8'($urandom);
    xfer8(tx, mw, 20, lat);
    repeat (40) tick8();
    total++; if (n_shclk !== N8 || n_done !== 1 || n_load !== 1) begin
      bad++; $display("FAIL held_single got=%0d/%0d/%0d want=%0d/1/1", n_shclk, n_done, n_load, N8);
    end
    total++; if (rx8 !== mw || busy8 !== 1'b0) begin
      bad++; $display("FAIL held_rx got=%h/%b want=%h/0", rx8, busy8, mw);
    end
  endtask

  task automatic test_random();
    int lat;
    logic [7:0] tx, mw;
    int exp_lat = 2 + D8 + 2 * N8 * D8;
    for (int i = 0; i < 6; i++) begin
      tx = 8'($urandom); mw = 8'($urandom);
      xfer8(tx, mw, 1, lat);
      total++;
      if (lat !== exp_lat || mosi_got !== tx || rx8 !== mw || n_rise !== N8) begin
        bad++; $display("FAIL random_%0d got=lat%0d/mosi%h/rx%h/rise%0d want=lat%0d/mosi%h/rx%h/rise%0d",
                        i, lat, mosi_got, rx8, n_rise, exp_lat, tx, mw, N8);
      end
    end
  endtask

`ifdef SPI_CS_HOLD_EN
  task automatic test_cs_hold();
    int lat;
    hold8 = 1'b1;
    xfer8(8'h40, 8'h95, 1, lat);
    total++; if (cs_hi !== 0) begin bad++; $display("FAIL hold_first got=%0d want=0", cs_hi); end
    xfer8(8'h00, 8'h01, 1, lat);
    total++; if (idle_cs !== 1'b0 || cs_hi !== 0) begin
      bad++; $display("FAIL hold_second got=%b/%0d want=0/0", idle_cs, cs_hi);
    end
    hold8 = 1'b0;
    xfer8(8'h95, 8'hC3, 1, lat);
    total++; if (idle_cs !== 1'b0 || cs_hi !== 0 || rx8 !== 8'hC3) begin
      bad++; $display("FAIL hold_third got=%b/%0d/%h want=0/0/c3", idle_cs, cs_hi, rx8);
    end
    tick8();
    total++; if (cs_n8 !== 1'b1) begin bad++; $display("FAIL hold_release got=%b want=1", cs_n8); end
  endtask
`endif

  task automatic test_wide();
    int lat = -1, rises = 0, falls = 0, hi_run = 0, lo_run = 0, hi_bad = 0, lo_bad = 0, shc = 0;
    logic prev = 1'b0;
    logic [15:0] mw = 16'($urandom);
    int exp_lat = 2 + D16 + 2 * N16 * D16;
    @(negedge clk);
    tx16 = 16'($urandom); miso16 = mw[15]; start16 = 1'b1;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      start16 = 1'b0;
      if (sc16) shc++;
      if (sclk16) begin
        if (!prev) begin
          rises++;
          if (rises > 1 && lo_run != D16) lo_bad++;
          hi_run = 0;
        end
        hi_run++;
      end else begin
        if (prev) begin
          falls++;
          if (hi_run != D16) hi_bad++;
          lo_run = 0;
          if (falls < N16) miso16 = mw[15 - falls];
        end
        lo_run++;
      end
      prev = sclk16;
      if (done16) begin lat = k; break; end
    end
    total++; if (lat !== exp_lat) begin bad++; $display("FAIL wide_latency got=%0d want=%0d", lat, exp_lat); end
    total++; if (rises !== N16 || shc !== N16) begin
      bad++; $display("FAIL wide_pulses got=%0d/%0d want=%0d/%0d", rises, shc, N16, N16);
    end
    total++; if (hi_bad !== 0 || lo_bad !== 0 || lo_run !== D16 + 1) begin
      bad++; $display("FAIL wide_phases got=%0d/%0d/%0d want=0/0/%0d", hi_bad, lo_bad, lo_run, D16 + 1);
    end
    total++; if (rx16 !== mw || sd16 !== tx16) begin
      bad++; $display("FAIL wide_data got=%h/%h want=%h/%h", rx16, sd16, mw, tx16);
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    tick8();
    clear8();
    miso_word = 8'h5A; miso8 = 1'b0; tx8 = 8'hC7; start8 = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      tick8();
      start8 = 1'b0;
      if (n_rise == 4) begin seen = 1; break; end
    end
    total++; if (seen !== 1) begin bad++; $display("FAIL rstmid_reach got=%0d want=1", seen); end
    reset = 1'b1;
    #1;
    total++; if ({cs_n8, sclk8, busy8, done8} !== 4'b1000) begin
      bad++; $display("FAIL rstmid_async got=%b want=1000", {cs_n8, sclk8, busy8, done8});
    end
    total++; if (rx8 !== 8'h00) begin bad++; $display("FAIL rstmid_rx got=%h want=00", rx8); end
    @(negedge clk);
    reset = 1'b0;
    clear8();
    repeat (60) tick8();
    total++; if (n_done !== 0 || n_rise !== 0 || n_busy !== 0) begin
      bad++; $display("FAIL rstmid_quiet got=%0d/%0d/%0d want=0/0/0", n_done, n_rise, n_busy);
    end
  endtask

  initial begin
    reset = 1'b1;
    start8 = 1'b0; tx8 = '0; miso8 = 1'b0;
    start16 = 1'b0; tx16 = '0; miso16 = 1'b0;
    stage8 = '0; mosi8 = 1'b0; prev_sclk = 1'b0; miso_word = '0;
    clear8();
    test_reset();
    test_basic();
    test_back_to_back();
    test_start_held();
    test_random();
`ifdef SPI_CS_HOLD_EN
    test_cs_hold();
`endif
    test_wide();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
